aq_axis_fifo_arb: RTL

//  N-input AXI-Stream packet arbiter sharing the single write port of an aq_axis_fifo.
//  - Grants one slave port per packet (TLAST-delimited), round-robin; never interleaves beats of two packets.
//  - Throttles new packet starts while the downstream FIFO reports almost-full.
//  - Sits between the requesters and the FIFO S_AXIS side, in the FIFO write-clock domain.

---
 rtl/aq_axis_fifo_arb_pkg.sv | 31 +++
 rtl/aq_axis_fifo_arb_rr_pick.sv | 32 +++
 rtl/aq_axis_fifo_arb.sv | 134 +++++++++++++
 3 files changed

// File: rtl/aq_axis_fifo_arb_pkg.sv
// Shared types and helpers for the aq_axis_fifo_arb packet arbiter.
package aq_axis_fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        XFER = 2'd2
    } arb_state_e;

    localparam int MAX_PORTS = 8;
    localparam int GW_MAX    = $clog2(MAX_PORTS);

    // Reference round-robin pick: first set bit of req at or after ptr, wrapping modulo n.
    function automatic logic [GW_MAX-1:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                                  input logic [GW_MAX-1:0]    ptr,
                                                  input int                   n);
        logic [GW_MAX-1:0] pick;
        logic [GW_MAX-1:0] pos;
        int                idx;
        pick = ptr;
        for (int k = MAX_PORTS-1; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                pos = GW_MAX'(idx);
                if (req[pos]) pick = pos;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/aq_axis_fifo_arb_rr_pick.sv
// Combinational round-robin picker: rotate by pointer, priority-encode, unrotate.
module aq_axis_rr_pick
    import aq_axis_fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int GW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [GW-1:0] ptr_i,
    output logic          vld_o,
    output logic [GW-1:0] idx_o
);

    localparam logic [GW:0] NL = (GW+1)'(N);

    logic [N-1:0]  rot;
    logic [GW-1:0] off;
    logic [GW:0]   sum;

    always_comb begin
        rot = N'({req_i, req_i} >> ptr_i);
        off = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (rot[i]) off = GW'(i);
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= NL) sum = sum - NL;
        vld_o = |rot;
        idx_o = sum[GW-1:0];
    end

endmodule

// File: rtl/aq_axis_fifo_arb.sv
// N-input AXI-Stream packet arbiter feeding the write port of an aq_axis_fifo.
// Optional per-port packet counters are built when AQ_AXIS_FIFO_ARB_STATS_EN is defined.
module aq_axis_fifo_arb
    import aq_axis_fifo_arb_pkg::*;
#(
    parameter  int NUM_PORTS  = 4,
    parameter  int FIFO_WIDTH = 32,
    localparam int GW         = $clog2(NUM_PORTS)
) (
    input  logic                            ACLK,
    input  logic                            RST,
    input  logic [NUM_PORTS-1:0]            S_AXIS_TVALID,
    output logic [NUM_PORTS-1:0]            S_AXIS_TREADY,
    input  logic [NUM_PORTS-1:0]            S_AXIS_TLAST,
    input  logic [NUM_PORTS*FIFO_WIDTH-1:0] S_AXIS_TDATA,
    output logic                            M_AXIS_TVALID,
    input  logic                            M_AXIS_TREADY,
    output logic                            M_AXIS_TLAST,
    output logic [FIFO_WIDTH-1:0]           M_AXIS_TDATA,
    input  logic                            FIFO_WR_ALM_FULL,
    output logic [GW-1:0]                   GRANT,
    output logic                            BUSY
`ifdef AQ_AXIS_FIFO_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*16-1:0]         PKT_COUNT
`endif
);

    arb_state_e           state_q;
    logic [NUM_PORTS-1:0] req_q;
    logic [GW-1:0]        grant_q;
    logic [GW-1:0]        ptr_q;
    logic [GW-1:0]        ptr_d;
    logic                 busy_q;
    logic                 pick_vld;
    logic [GW-1:0]        pick_idx;
    logic                 xfer;
    logic                 beat_last;

    // Requests that vanished between IDLE and ARB are masked so ARB can fall back to IDLE.
    aq_axis_rr_pick #(
        .N  (NUM_PORTS),
        .GW (GW)
    ) u_pick (
        .req_i (req_q & S_AXIS_TVALID),
        .ptr_i (ptr_q),
        .vld_o (pick_vld),
        .idx_o (pick_idx)
    );

    assign xfer = (state_q == XFER);

    always_comb begin
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        M_AXIS_TDATA  = '0;
        S_AXIS_TREADY = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (xfer && grant_q == GW'(p)) begin
                M_AXIS_TVALID    = S_AXIS_TVALID[p];
                M_AXIS_TLAST     = S_AXIS_TLAST[p];
                M_AXIS_TDATA     = S_AXIS_TDATA[p*FIFO_WIDTH +: FIFO_WIDTH];
                S_AXIS_TREADY[p] = M_AXIS_TREADY;
            end
        end
    end

    assign beat_last = M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST;
    assign ptr_d     = (grant_q == GW'(NUM_PORTS-1)) ? '0 : grant_q + GW'(1);

    always_ff @(posedge ACLK) begin
        if (RST) begin
            state_q <= IDLE;
            req_q   <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|S_AXIS_TVALID && !FIFO_WR_ALM_FULL) begin
                        req_q   <= S_AXIS_TVALID;
                        state_q <= ARB;
                        busy_q  <= 1'b1;
                    end
                end
                ARB: begin
                    if (pick_vld) begin
                        grant_q <= pick_idx;
                        state_q <= XFER;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                XFER: begin
                    if (beat_last) begin
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign GRANT = grant_q;
    assign BUSY  = busy_q;

`ifdef AQ_AXIS_FIFO_ARB_STATS_EN
    logic [NUM_PORTS-1:0][15:0] cnt_q;
    logic [NUM_PORTS-1:0][15:0] cnt_d;

    // 16-bit counters wrap naturally at 0xFFFF.
    always_comb begin
        cnt_d = cnt_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (beat_last && grant_q == GW'(p)) cnt_d[p] = cnt_q[p] + 16'd1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign PKT_COUNT = cnt_q;
`endif

endmodule
